swi_debounce: RTL and testbench



---
 rtl/loac_pkg.sv | 25 ++
 rtl/debounce_bit.sv | 102 ++++++++++
 rtl/swi_debounce.sv | 68 ++++++
 tb/tb_swi_debounce.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loac_pkg.sv
// -----------------------------------------------------------------------------
// loac_pkg
// Shared definitions for the board input-conditioning path and the display
// logic that consumes it.
//
// Contents:
//   NBITS_TOP        width of the board switch bank
//   DEBOUNCE_CYCLES  default stability window, in synchronized clk_2 cycles
//   swi_t            switch-bank vector type
//   cnt_width()      stability-counter width for a given window (minimum 1)
// -----------------------------------------------------------------------------
package loac_pkg;

    localparam int unsigned NBITS_TOP       = 8;
    localparam int unsigned DEBOUNCE_CYCLES = 4;

    typedef logic [NBITS_TOP-1:0] swi_t;

    // The counter only has to reach STABLE_CYCLES-1. A one-cycle window still
    // needs a 1-bit counter so that the vector is never zero width.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return ($clog2(stable_cycles) > 0) ? $clog2(stable_cycles) : 1;
    endfunction

endpackage : loac_pkg

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Conditions one raw switch bit: a 2-FF synchronizer into the clk_2 domain,
// then a stability counter. A new level is accepted only after it has been
// seen on the synchronized input for STABLE_CYCLES consecutive cycles.
//
// Ports:
//   clk_2       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   raw_i       in   asynchronous raw switch level
//   clean_o     out  debounced level (registered)
//   rise_o      out  one-cycle pulse when clean_o goes 0->1 (registered)
//   fall_o      out  one-cycle pulse when clean_o goes 1->0 (registered)
//   change_d_o  out  next-state of (rise_o | fall_o); lets the parent register
//                    an aggregate change flag aligned with the pulses
// -----------------------------------------------------------------------------
module debounce_bit
    import loac_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W         = cnt_width(STABLE_CYCLES)
) (
    input  logic clk_2,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic change_d_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronizer stages. s1_q may go metastable; only s2_q is used.
    logic s1_q;
    logic s2_q;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves a signal unassigned and infers a latch.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (s2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                // The mismatch has now lasted the whole window: accept it.
                // cnt_d stays at its cleared default for the next event.
                clean_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        // A matching cycle leaves cnt_d at 0: a single agreeing sample
        // discards any partial count, which is what rejects bounces.
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that s2_q
    // samples the previous value of s1_q, forming two real flop stages.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o    = clean_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign change_d_o = rise_d | fall_d;

endmodule : debounce_bit

// File: rtl/swi_debounce.sv
// -----------------------------------------------------------------------------
// swi_debounce
// Input-conditioning stage between the board switch bank and the display
// logic. Each bit is synchronized to clk_2 and debounced independently; the
// block presents clean levels plus one-cycle rise/fall pulses and a single
// any_change flag. Every output comes straight from a flop.
//
// Ports:
//   clk_2       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   swi_raw     in   [NBITS] asynchronous raw switch levels
//   swi_clean   out  [NBITS] debounced, synchronized levels
//   rise        out  [NBITS] one-cycle pulse per bit on clean 0->1
//   fall        out  [NBITS] one-cycle pulse per bit on clean 1->0
//   any_change  out  |(rise | fall), high in the same cycle as the pulses
// -----------------------------------------------------------------------------
module swi_debounce
    import loac_pkg::*;
#(
    parameter int unsigned NBITS         = NBITS_TOP,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W         =
        ($clog2(STABLE_CYCLES) > 0) ? $clog2(STABLE_CYCLES) : 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_clean,
    output logic [NBITS-1:0] rise,
    output logic [NBITS-1:0] fall,
    output logic             any_change
);

    logic [NBITS-1:0] change_d;
    logic             any_change_q;
    logic             any_change_d;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk_2      (clk_2),
            .reset      (reset),
            .raw_i      (swi_raw[i]),
            .clean_o    (swi_clean[i]),
            .rise_o     (rise[i]),
            .fall_o     (fall[i]),
            .change_d_o (change_d[i])
        );
    end

    // Reducing the per-bit pulse next-states (rather than the registered
    // pulses) keeps any_change on the same edge as rise/fall, while it still
    // leaves the block from a flop.
    assign any_change_d = |change_d;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            any_change_q <= 1'b0;
        end else begin
            any_change_q <= any_change_d;
        end
    end

    assign any_change = any_change_q;

endmodule : swi_debounce

// File: tb/tb_swi_debounce.sv
// -----------------------------------------------------------------------------
// tb_swi_debounce
// Drives two builds of swi_debounce (default window and a one-cycle window)
// from the same stimulus. A behavioural model predicts each build's outputs
// for the coming edge; the prediction is queued when the stimulus is applied
// and popped and compared once the edge has produced the DUT outputs.
// -----------------------------------------------------------------------------
module tb_swi_debounce;
    import loac_pkg::*;

    localparam int SC0 = DEBOUNCE_CYCLES;
    localparam int SC1 = 1;

    logic clk_2 = 1'b0;
    logic reset;
    swi_t swi_raw;

    swi_t clean0, rise0, fall0;
    logic any0;
    swi_t clean1, rise1, fall1;
    logic any1;

    always #5 clk_2 = ~clk_2;

    swi_debounce #(.NBITS(NBITS_TOP), .STABLE_CYCLES(SC0)) dut0 (
        .clk_2      (clk_2),
        .reset      (reset),
        .swi_raw    (swi_raw),
        .swi_clean  (clean0),
        .rise       (rise0),
        .fall       (fall0),
        .any_change (any0)
    );

    swi_debounce #(.NBITS(NBITS_TOP), .STABLE_CYCLES(SC1)) dut1 (
        .clk_2      (clk_2),
        .reset      (reset),
        .swi_raw    (swi_raw),
        .swi_clean  (clean1),
        .rise       (rise1),
        .fall       (fall1),
        .any_change (any1)
    );

    typedef struct packed {
        swi_t clean;
        swi_t rise;
        swi_t fall;
        logic any;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // The model tracks, per bit, how many consecutive synchronized samples
    // have disagreed with the accepted level; reaching the window length
    // accepts the new level.
    swi_t m_p1[2], m_p2[2], m_clean[2], m_rise[2], m_fall[2];
    logic m_any[2];
    int   m_run[2][NBITS_TOP];

    task automatic model_step(input int k, input int sc, input logic rst, input swi_t raw);
        if (rst) begin
            m_p1[k] = '0; m_p2[k] = '0; m_clean[k] = '0;
            m_rise[k] = '0; m_fall[k] = '0; m_any[k] = 1'b0;
            for (int i = 0; i < NBITS_TOP; i++) m_run[k][i] = 0;
        end else begin
            m_rise[k] = '0;
            m_fall[k] = '0;
            for (int i = 0; i < NBITS_TOP; i++) begin
                if (m_p2[k][i] != m_clean[k][i]) begin
                    m_run[k][i]++;
                    if (m_run[k][i] == sc) begin
                        m_clean[k][i] = m_p2[k][i];
                        m_rise[k][i]  = m_p2[k][i];
                        m_fall[k][i]  = ~m_p2[k][i];
                        m_run[k][i]   = 0;
                    end
                end else begin
                    m_run[k][i] = 0;
                end
            end
            m_p2[k]  = m_p1[k];
            m_p1[k]  = raw;
            m_any[k] = |(m_rise[k] | m_fall[k]);
        end
    endtask

    // -------------------------------------------------------------- monitor
    always @(posedge clk_2) begin : mon
        obs_t e;
        #1;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("d0_clean", clean0, e.clean);
            check("d0_rise",  rise0,  e.rise);
            check("d0_fall",  fall0,  e.fall);
            check("d0_any",   any0,   e.any);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("d1_clean", clean1, e.clean);
            check("d1_rise",  rise1,  e.rise);
            check("d1_fall",  fall1,  e.fall);
            check("d1_any",   any1,   e.any);
        end
    end

    // --------------------------------------------------------------- driver
    // Called on a falling edge; returns on the next falling edge, by which
    // time the intervening rising edge has updated the DUT outputs.
    task automatic cycle(input swi_t raw, input logic rst);
        swi_raw = raw;
        reset   = rst;
        model_step(0, SC0, rst, raw);
        model_step(1, SC1, rst, raw);
        exp_q0.push_back({m_clean[0], m_rise[0], m_fall[0], m_any[0]});
        exp_q1.push_back({m_clean[1], m_rise[1], m_fall[1], m_any[1]});
        @(negedge clk_2);
    endtask

    // Directed observations gathered across hold() calls.
    int   lat0, lat1, rise0_cnt, any0_cnt;
    swi_t pulse_acc0, cap_rise0, cap_fall0, cap_rise1;
    logic cap_any0;

    task automatic clear_stats();
        lat0 = 0; lat1 = 0; rise0_cnt = 0; any0_cnt = 0;
        pulse_acc0 = '0; cap_rise0 = '0; cap_fall0 = '0; cap_rise1 = '0;
        cap_any0 = 1'b0;
    endtask

    // Holds raw for n cycles; lat0/lat1 record the 1-based edge on which each
    // build first shows raw on swi_clean.
    task automatic hold(input swi_t raw, input int n);
        for (int k = 1; k <= n; k++) begin
            cycle(raw, 1'b0);
            if (lat0 == 0 && clean0 == raw) begin
                lat0 = k; cap_rise0 = rise0; cap_fall0 = fall0; cap_any0 = any0;
            end
            if (lat1 == 0 && clean1 == raw) begin
                lat1 = k; cap_rise1 = rise1;
            end
            pulse_acc0 |= rise0 | fall0;
            if (rise0 != '0) rise0_cnt++;
            if (any0) any0_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        swi_raw = '0;
        reset   = 1'b1;
        @(negedge clk_2);

        // Reset with all switches up, then release.
        cycle(8'hFF, 1'b1);
        cycle(8'hFF, 1'b1);
        check("rst_clean", clean0, 8'h00);
        check("rst_rise",  rise0,  8'h00);
        check("rst_any",   any0,   1'b0);
        clear_stats();
        hold(8'hFF, 10);
        check("rel_latency", lat0, 6);
        check("rel_rise",    cap_rise0, 8'hFF);
        check("rel_any",     cap_any0, 1'b1);
        check("rel_any_cnt", any0_cnt, 1);

        // Clean single-bit step.
        hold(8'h00, 8);
        clear_stats();
        hold(8'h80, 8);
        check("step_latency", lat0, 6);
        check("step_rise",    cap_rise0, 8'h80);
        check("step_fall",    cap_fall0, 8'h00);
        check("step_rise_cnt", rise0_cnt, 1);

        // Bounce on bit 3 shorter than the window.
        hold(8'h00, 8);
        clear_stats();
        hold(8'h08, 3);
        hold(8'h00, 1);
        hold(8'h08, 2);
        hold(8'h00, 8);
        check("bounce_pulses", pulse_acc0, 8'h00);
        check("bounce_clean",  clean0, 8'h00);

        // Simultaneous mixed transitions.
        hold(8'h0F, 8);
        clear_stats();
        hold(8'hF0, 8);
        check("mix_latency", lat0, 6);
        check("mix_rise",    cap_rise0, 8'hF0);
        check("mix_fall",    cap_fall0, 8'h0F);
        check("mix_any",     cap_any0, 1'b1);
        check("mix_any_cnt", any0_cnt, 1);

        // Reset in the middle of a count.
        hold(8'h00, 8);
        clear_stats();
        hold(8'h01, 3);
        cycle(8'h01, 1'b1);
        check("midrst_clean", clean0, 8'h00);
        check("midrst_any",   any0,   1'b0);
        clear_stats();
        hold(8'h01, 10);
        check("midrst_latency",  lat0, 6);
        check("midrst_rise_cnt", rise0_cnt, 1);

        // One-cycle window build.
        hold(8'h00, 8);
        clear_stats();
        hold(8'h02, 5);
        check("sc1_latency", lat1, 3);
        check("sc1_rise",    cap_rise1, 8'h02);

        // Random levels with random hold lengths and occasional resets.
        clear_stats();
        for (int r = 0; r < 40; r++) begin
            swi_t v;
            v = swi_t'($urandom);
            if ($urandom_range(0, 19) == 0) cycle(v, 1'b1);
            hold(v, $urandom_range(1, 7));
        end
        hold(8'h00, 8);

        @(negedge clk_2);
        check("sb_drain0", exp_q0.size(), 0);
        check("sb_drain1", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_swi_debounce
